uart_tx_cfg: RTL and testbench

Parametrised UART transmitter that serialises one word per valid/ready handshake onto a single `tx` line. Data width, parity mode, stop-bit count and baud rate are set at elaboration time. It replaces the fixed 8N1 transmitter in every UART path of the design, and sits between a byte/word source (FIFO or command engine) and the pad. Framing adds optional parity, 2 stop bits, a ready handshake that allows back-to-back frames, and a per-frame completion pulse.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/uart_tx_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART blocks. It holds the parity
//               mode encodings, the transmitter state encoding, and the
//               bit-period calculation. TX and RX both use
//               calc_bit_period, so they round the bit period the same way.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } uart_tx_state_t;

    // Clock cycles per bit. Integer division rounds down.
    function automatic int calc_bit_period(input longint clk_hz, input longint baud);
        return int'(clk_hz / baud);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter. It counts 0..BIT_PERIOD-1 and wraps.
//               'restart' forces the count back to 0, so a new frame lines up
//               with the edge on which it was accepted.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               restart  - clear the count to 0 on this edge
//               bit_tick - high during the last cycle of each bit period
//               count    - current position inside the bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int BIT_PERIOD = 10,
    parameter int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    output logic             bit_tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(BIT_PERIOD - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_count <= '0;
        end else if (r_count == c_last_count) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bit_tick = (r_count == c_last_count);
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Configurable UART transmitter. It sends one word for each
//               valid/ready handshake, with optional even or odd parity and
//               1 or 2 stop bits. Words are sent LSB first.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               tx_valid - a word is offered on tx_data
//               tx_data  - word to send
//               tx_ready - a word is accepted on an edge where valid && ready
//               tx       - registered serial line; idles high
//               busy     - a frame is in progress
//               tx_done  - one-cycle pulse as the last stop bit completes
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 60000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BIT_PERIOD = calc_bit_period(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    localparam logic [CNT_W-1:0] c_pre_last = CNT_W'(BIT_PERIOD - 2);
    localparam logic [2:0]       c_last_idx = 3'(DATA_BITS - 1);
    localparam logic             c_last_stop = 1'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be in 5..8");
        end
        if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (BIT_PERIOD < 2) begin : g_bad_bit_period
            $error("uart_tx_cfg: CLK_FREQ / BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_tx_state_t       r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_idx;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_done;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_pre_tick;
    logic                 w_parity;
    logic [CNT_W-1:0]     w_count;

    assign w_ready  = (r_state == TX_IDLE) && !rst;
    assign w_accept = tx_valid && w_ready;

    // The parity is taken from tx_data on the acceptance edge. That is the
    // same value that is loaded into the shift register.
    assign w_parity = (^tx_data) ^ (PARITY == PARITY_ODD);

    // Fires one cycle before the bit boundary. It ends the last stop bit.
    assign w_pre_tick = (w_count == c_pre_last);

    uart_baud_gen #(
        .BIT_PERIOD (BIT_PERIOD),
        .CNT_W      (CNT_W)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .restart  (w_accept),
        .bit_tick (w_tick),
        .count    (w_count)
    );

    // The FSM leaves STOP one cycle before the last stop bit's boundary. The
    // IDLE cycle (tx high, tx_ready and tx_done high) is therefore the last
    // cycle of that stop bit. A word accepted in that cycle starts its start
    // bit on the frame boundary, so back-to-back frames leave no idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_idx      <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_valid) begin
                        r_state    <= TX_START;
                        r_shift    <= tx_data;
                        r_parity   <= w_parity;
                        r_idx      <= 3'd0;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_tick) begin
                        r_state <= TX_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        if (r_idx == c_last_idx) begin
                            if (PARITY != PARITY_NONE) begin
                                r_state <= TX_PAR;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= TX_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                TX_PAR: begin
                    if (w_tick) begin
                        r_state <= TX_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                TX_STOP: begin
                    r_tx <= 1'b1;
                    if (r_stop_cnt == c_last_stop && w_pre_tick) begin
                        r_state <= TX_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = w_ready;
    assign tx       = r_tx;
    assign busy     = (r_state != TX_IDLE);
    assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Directed self-checking bench for uart_tx_cfg. It runs three
//               instances: 8N1, 7E2 and 8O1, each with a bit period of
//               10 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int BP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din  [3];
    logic       vin  [3];
    logic       tx_o [3];
    logic       rdy_o[3];
    logic       bsy_o[3];
    logic       dn_o [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(vin[0]), .tx_data(din[0]),
        .tx_ready(rdy_o[0]), .tx(tx_o[0]), .busy(bsy_o[0]), .tx_done(dn_o[0]));

    uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2)) u_7e2 (
        .clk(clk), .rst(rst), .tx_valid(vin[1]), .tx_data(din[1][6:0]),
        .tx_ready(rdy_o[1]), .tx(tx_o[1]), .busy(bsy_o[1]), .tx_done(dn_o[1]));

    uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_valid(vin[2]), .tx_data(din[2]),
        .tx_ready(rdy_o[2]), .tx(tx_o[2]), .busy(bsy_o[2]), .tx_done(dn_o[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int u);
        int n;
        n = 0;
        @(negedge clk);
        while (rdy_o[u] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(n < 500), 1);
    endtask

    // Sends one word and checks the line cycle by cycle. Bit j of 'line' is
    // the level expected during bit period j, with the start bit in bit 0.
    task automatic run_frame(input int u, input logic [7:0] word,
                             input logic [19:0] line, input int nbits,
                             input bit scramble, input string tag);
        int f, bad_tx, bad_done, bad_rdy;
        f = nbits * BP;
        bad_tx = 0; bad_done = 0; bad_rdy = 0;
        wait_ready(u);
        din[u] = word;
        vin[u] = 1'b1;
        @(posedge clk);
        #1 vin[u] = 1'b0;
        for (int i = 0; i < f; i++) begin
            @(negedge clk);
            if (scramble) din[u] = 8'($urandom);
            if (tx_o[u]  !== line[i / BP]) bad_tx++;
            if (dn_o[u]  !== (i == f - 1)) bad_done++;
            if (rdy_o[u] !== (i == f - 1)) bad_rdy++;
        end
        chk({tag, "_line"},  bad_tx,   0);
        chk({tag, "_done"},  bad_done, 0);
        chk({tag, "_ready"}, bad_rdy,  0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, dones, rdys;
        logic [19:0] two;
        for (int u = 0; u < 3; u++) begin
            din[u] = 8'h00;
            vin[u] = 1'b0;
        end

        // Behaviour during and straight after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx",    int'(tx_o[0]),  1);
        chk("rst_busy",  int'(bsy_o[1]), 0);
        chk("rst_ready", int'(rdy_o[2]), 0);
        chk("rst_done",  int'(dn_o[0]),  0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(rdy_o[0]), 1);

        // 8N1 0xA5
        run_frame(0, 8'hA5, 20'({1'b1, 8'hA5, 1'b0}), 10, 1'b0, "8n1_a5");
        // 7E2 0x53: 0x53 has four set bits, so even parity gives 0
        run_frame(1, 8'h53, 20'({2'b11, 1'b0, 7'h53, 1'b0}), 11, 1'b0, "7e2_53");
        // 8O1 0x00: odd parity gives 1
        run_frame(2, 8'h00, 20'({1'b1, 1'b1, 8'h00, 1'b0}), 11, 1'b0, "8o1_00");

        // Back-to-back frames: 0x0F, then 0xF0, with tx_valid held high
        two = {1'b1, 8'hF0, 1'b0, 1'b1, 8'h0F, 1'b0};
        bad = 0; dones = 0; rdys = 0;
        wait_ready(0);
        din[0] = 8'h0F;
        vin[0] = 1'b1;
        @(posedge clk);
        #1 din[0] = 8'hF0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 100) vin[0] = 1'b0;
            if (tx_o[0] !== two[i / BP]) bad++;
            if (dn_o[0] === 1'b1) dones++;
            if (rdy_o[0] === 1'b1) rdys++;
            if (i == 99 || i == 199) chk("b2b_ready_at_boundary", int'(rdy_o[0]), 1);
            if (i == 100) chk("b2b_second_start", int'(tx_o[0]), 0);
        end
        chk("b2b_line",  bad,   0);
        chk("b2b_dones", dones, 2);
        chk("b2b_ready", rdys,  2);

        // Reset during a frame: rst is sampled 35 cycles after accepting 0x3C
        wait_ready(0);
        din[0] = 8'h3C;
        vin[0] = 1'b1;
        @(posedge clk);
        #1 vin[0] = 1'b0;
        for (int i = 0; i < 35; i++) @(negedge clk);
        chk("mid_busy_before", int'(bsy_o[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx",   int'(tx_o[0]),  1);
        chk("mid_rst_busy", int'(bsy_o[0]), 0);
        chk("mid_rst_done", int'(dn_o[0]),  0);
        rst = 1'b0;
        dones = 0; bad = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (dn_o[0] === 1'b1) dones++;
            if (tx_o[0] !== 1'b1) bad++;
        end
        chk("mid_no_done", dones, 0);
        chk("mid_line_idle", bad, 0);
        run_frame(0, 8'h81, 20'({1'b1, 8'h81, 1'b0}), 10, 1'b0, "after_rst_81");

        // Reset and tx_valid in the same cycle: the reset wins
        @(negedge clk);
        rst = 1'b1;
        din[0] = 8'h12;
        vin[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vin[0] = 1'b0;
        @(negedge clk);
        chk("rst_wins_busy", int'(bsy_o[0]), 0);
        chk("rst_wins_tx",   int'(tx_o[0]),  1);

        // tx_data changes every cycle after 0x55 is accepted
        run_frame(0, 8'h55, 20'({1'b1, 8'h55, 1'b0}), 10, 1'b1, "stable_55");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
